// File: rtl/control_sequencer_if.sv
// Control interface between the micro-step sequencer and the CPU datapath.
// Carries run/opcode/flags into the sequencer and every register strobe out of it.
interface control_sequencer_if #(
    parameter int unsigned OPW = 4
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic           cf;
    logic           zf;

    logic           pc_inc;
    logic           pc_rd;
    logic           pc_wr;
    logic           mar_wr;
    logic           ram_rd;
    logic           ram_wr;
    logic           ir_wr;
    logic           ir_rd;
    logic           a_wr;
    logic           a_rd;
    logic           b_wr;
    logic           alu_rd;
    logic           alu_sub;
    logic           flag_wr;
    logic           out_wr;
    logic           halted;
    logic [2:0]     step;

    modport master (
        input  run, opcode, cf, zf,
        output pc_inc, pc_rd, pc_wr, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd,
               a_wr, a_rd, b_wr, alu_rd, alu_sub, flag_wr, out_wr, halted, step
    );

    modport slave (
        output run, opcode, cf, zf,
        input  pc_inc, pc_rd, pc_wr, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd,
               a_wr, a_rd, b_wr, alu_rd, alu_sub, flag_wr, out_wr, halted, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Micro-step sequencer and instruction decoder for the 8-bit bus CPU.
// Steps T0..T4 per instruction; strobes decode from (step, opcode, flags).
module control_sequencer #(
    parameter int unsigned OPW   = 4,
    parameter int unsigned STEPS = 5
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    step_t state_q, state_n;
    logic  halted_q, halted_n;
    logic  last, hlt_end, en;

    logic d_pc_inc, d_pc_rd, d_pc_wr, d_mar_wr, d_ram_rd, d_ram_wr, d_ir_wr;
    logic d_ir_rd, d_a_wr, d_a_rd, d_b_wr, d_alu_rd, d_alu_sub, d_flag_wr, d_out_wr;

    // State register: step counter and sticky halt flag
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            halted_q <= halted_n;
        end
    end

    // Instruction decode and next-step selection
    always_comb begin
        d_pc_inc  = 1'b0;
        d_pc_rd   = 1'b0;
        d_pc_wr   = 1'b0;
        d_mar_wr  = 1'b0;
        d_ram_rd  = 1'b0;
        d_ram_wr  = 1'b0;
        d_ir_wr   = 1'b0;
        d_ir_rd   = 1'b0;
        d_a_wr    = 1'b0;
        d_a_rd    = 1'b0;
        d_b_wr    = 1'b0;
        d_alu_rd  = 1'b0;
        d_alu_sub = 1'b0;
        d_flag_wr = 1'b0;
        d_out_wr  = 1'b0;
        last      = 1'b0;
        hlt_end   = 1'b0;
        state_n   = state_q;
        halted_n  = halted_q;

        case (state_q)
            T0: begin
                d_pc_rd  = 1'b1;
                d_mar_wr = 1'b1;
            end
            T1: begin
                d_ram_rd = 1'b1;
                d_ir_wr  = 1'b1;
                d_pc_inc = 1'b1;
            end
            T2: begin
                last = 1'b1;
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        d_ir_rd  = 1'b1;
                        d_mar_wr = 1'b1;
                        last     = 1'b0;
                    end
                    OP_LDI: begin
                        d_ir_rd = 1'b1;
                        d_a_wr  = 1'b1;
                    end
                    OP_JMP: begin
                        d_ir_rd = 1'b1;
                        d_pc_wr = 1'b1;
                    end
                    OP_JC: begin
                        d_ir_rd = bus.cf;
                        d_pc_wr = bus.cf;
                    end
                    OP_JZ: begin
                        d_ir_rd = bus.zf;
                        d_pc_wr = bus.zf;
                    end
                    OP_OUT: begin
                        d_a_rd   = 1'b1;
                        d_out_wr = 1'b1;
                    end
                    OP_HLT:  hlt_end = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (bus.opcode)
                    OP_LDA: begin
                        d_ram_rd = 1'b1;
                        d_a_wr   = 1'b1;
                        last     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        d_ram_rd = 1'b1;
                        d_b_wr   = 1'b1;
                    end
                    OP_STA: begin
                        d_a_rd   = 1'b1;
                        d_ram_wr = 1'b1;
                        last     = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                last = 1'b1;
                if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                    d_alu_rd  = 1'b1;
                    d_a_wr    = 1'b1;
                    d_flag_wr = 1'b1;
                    d_alu_sub = (bus.opcode == OP_SUB);
                end
            end
            default: last = 1'b1;
        endcase

        // Out-of-range step values are never valid, so always fall back to T0
        if (32'(state_q) >= STEPS) begin
            last = 1'b1;
        end

        if (bus.run && !halted_q) begin
            if (last) begin
                state_n  = T0;
                halted_n = hlt_end;
            end else begin
                case (state_q)
                    T0:      state_n = T1;
                    T1:      state_n = T2;
                    T2:      state_n = T3;
                    T3:      state_n = T4;
                    default: state_n = T0;
                endcase
            end
        end
    end

    assign en = bus.run & ~halted_q & ~clr;

    assign bus.pc_inc  = en & d_pc_inc;
    assign bus.pc_rd   = en & d_pc_rd;
    assign bus.pc_wr   = en & d_pc_wr;
    assign bus.mar_wr  = en & d_mar_wr;
    assign bus.ram_rd  = en & d_ram_rd;
    assign bus.ram_wr  = en & d_ram_wr;
    assign bus.ir_wr   = en & d_ir_wr;
    assign bus.ir_rd   = en & d_ir_rd;
    assign bus.a_wr    = en & d_a_wr;
    assign bus.a_rd    = en & d_a_rd;
    assign bus.b_wr    = en & d_b_wr;
    assign bus.alu_rd  = en & d_alu_rd;
    assign bus.alu_sub = en & d_alu_sub;
    assign bus.flag_wr = en & d_flag_wr;
    assign bus.out_wr  = en & d_out_wr;
    assign bus.halted  = halted_q;
    assign bus.step    = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Each scenario task drives the sequencer and compares strobes/step against hand-derived vectors.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    control_sequencer_if #(.OPW(4)) bus ();
    control_sequencer #(.OPW(4), .STEPS(5)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // Strobe vector order: pc_inc pc_rd pc_wr mar_wr ram_rd ram_wr ir_wr ir_rd
    //                      a_wr a_rd b_wr alu_rd alu_sub flag_wr out_wr
    localparam logic [14:0] PC_INC  = 15'h4000;
    localparam logic [14:0] PC_RD   = 15'h2000;
    localparam logic [14:0] PC_WR   = 15'h1000;
    localparam logic [14:0] MAR_WR  = 15'h0800;
    localparam logic [14:0] RAM_RD  = 15'h0400;
    localparam logic [14:0] RAM_WR  = 15'h0200;
    localparam logic [14:0] IR_WR   = 15'h0100;
    localparam logic [14:0] IR_RD   = 15'h0080;
    localparam logic [14:0] A_WR    = 15'h0040;
    localparam logic [14:0] A_RD    = 15'h0020;
    localparam logic [14:0] B_WR    = 15'h0010;
    localparam logic [14:0] ALU_RD  = 15'h0008;
    localparam logic [14:0] ALU_SUB = 15'h0004;
    localparam logic [14:0] FLAG_WR = 15'h0002;
    localparam logic [14:0] OUT_WR  = 15'h0001;
    localparam logic [14:0] F0      = PC_RD | MAR_WR;
    localparam logic [14:0] F1      = RAM_RD | IR_WR | PC_INC;
    localparam logic [14:0] NONE    = 15'h0000;

    function automatic logic [14:0] strobes();
        return {bus.pc_inc, bus.pc_rd, bus.pc_wr, bus.mar_wr, bus.ram_rd, bus.ram_wr,
                bus.ir_wr, bus.ir_rd, bus.a_wr, bus.a_rd, bus.b_wr, bus.alu_rd,
                bus.alu_sub, bus.flag_wr, bus.out_wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.run = 1'b1;
        bus.opcode = 4'h0;
        bus.cf = 1'b0;
        bus.zf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (strobes() !== NONE) begin
                n_bad++;
                $display("FAIL reset_strobes cyc=%0d got=%h want=%h", i, strobes(), NONE);
            end
            n_cmp++;
            if (bus.step !== 3'd0 || bus.halted !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state step=%0d halted=%b want 0/0", bus.step, bus.halted);
            end
        end
        clr = 1'b0;
        #1;
        n_cmp++;
        if (strobes() !== F0) begin
            n_bad++;
            $display("FAIL fetch_t0 got=%h want=%h", strobes(), F0);
        end
        tick();
        n_cmp++;
        if (strobes() !== F1 || bus.step !== 3'd1) begin
            n_bad++;
            $display("FAIL fetch_t1 got=%h step=%0d want=%h step=1", strobes(), bus.step, F1);
        end
    endtask

    task automatic test_add_sub();
        logic [14:0] exp [5];
        for (int k = 0; k < 2; k++) begin
            bus.opcode = (k == 0) ? 4'h2 : 4'h3;
            do_reset();
            exp[0] = F0;
            exp[1] = F1;
            exp[2] = IR_RD | MAR_WR;
            exp[3] = RAM_RD | B_WR;
            exp[4] = ALU_RD | A_WR | FLAG_WR | ((k == 0) ? NONE : ALU_SUB);
            for (int i = 0; i < 5; i++) begin
                #1;
                n_cmp++;
                if (strobes() !== exp[i] || bus.step !== 3'(i)) begin
                    n_bad++;
                    $display("FAIL addsub op=%h T%0d got=%h step=%0d want=%h", bus.opcode, i,
                             strobes(), bus.step, exp[i]);
                end
                tick();
            end
            n_cmp++;
            if (bus.step !== 3'd0) begin
                n_bad++;
                $display("FAIL addsub_wrap op=%h step=%0d want 0", bus.opcode, bus.step);
            end
        end
    endtask

    task automatic test_cond_jump();
        logic [3:0]  ops  [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
        logic        flg  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [14:0] exp2 [4] = '{NONE, IR_RD | PC_WR, IR_RD | PC_WR, NONE};
        for (int k = 0; k < 4; k++) begin
            bus.opcode = ops[k];
            bus.cf = 1'b0;
            bus.zf = 1'b0;
            do_reset();
            tick();
            tick();
            // Flag arrives in the T2 cycle itself
            if (ops[k] == 4'h7) bus.cf = flg[k];
            else bus.zf = flg[k];
            #1;
            n_cmp++;
            if (strobes() !== exp2[k] || bus.step !== 3'd2) begin
                n_bad++;
                $display("FAIL cjump case=%0d got=%h step=%0d want=%h", k, strobes(), bus.step,
                         exp2[k]);
            end
            tick();
            n_cmp++;
            if (bus.step !== 3'd0) begin
                n_bad++;
                $display("FAIL cjump_len case=%0d step=%0d want 0", k, bus.step);
            end
        end
        bus.cf = 1'b0;
        bus.zf = 1'b0;
    endtask

    task automatic test_halt();
        bus.opcode = 4'hF;
        do_reset();
        tick();
        tick();
        #1;
        n_cmp++;
        if (strobes() !== NONE || bus.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_t2 got=%h halted=%b want=%h halted=0", strobes(), bus.halted, NONE);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (strobes() !== NONE || bus.step !== 3'd0 || bus.halted !== 1'b1) begin
                n_bad++;
                $display("FAIL halted cyc=%0d got=%h step=%0d halted=%b", i, strobes(), bus.step,
                         bus.halted);
            end
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus.halted !== 1'b0 || strobes() !== F0) begin
            n_bad++;
            $display("FAIL halt_clear halted=%b got=%h want halted=0 %h", bus.halted, strobes(), F0);
        end
    endtask

    task automatic test_run_gating();
        bus.opcode = 4'h1;
        do_reset();
        tick();
        tick();
        tick();
        bus.run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (strobes() !== NONE || bus.step !== 3'd3) begin
                n_bad++;
                $display("FAIL run_hold cyc=%0d got=%h step=%0d want=%h step=3", i, strobes(),
                         bus.step, NONE);
            end
            tick();
        end
        bus.run = 1'b1;
        #1;
        n_cmp++;
        if (strobes() !== (RAM_RD | A_WR) || bus.step !== 3'd3) begin
            n_bad++;
            $display("FAIL run_resume got=%h step=%0d want=%h", strobes(), bus.step, RAM_RD | A_WR);
        end
        tick();
        n_cmp++;
        if (bus.step !== 3'd0) begin
            n_bad++;
            $display("FAIL lda_len step=%0d want 0", bus.step);
        end
    endtask

    task automatic test_mid_reset();
        bus.opcode = 4'h4;
        do_reset();
        tick();
        tick();
        tick();
        clr = 1'b1;
        #1;
        n_cmp++;
        if (strobes() !== NONE) begin
            n_bad++;
            $display("FAIL sta_abort got=%h want=%h", strobes(), NONE);
        end
        tick();
        clr = 1'b0;
        #1;
        n_cmp++;
        if (bus.step !== 3'd0 || strobes() !== F0) begin
            n_bad++;
            $display("FAIL sta_restart step=%0d got=%h want step=0 %h", bus.step, strobes(), F0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3] = '{4'h5, 4'hE, 4'h6};
        logic [14:0] ex2 [3] = '{IR_RD | A_WR, A_RD | OUT_WR, IR_RD | PC_WR};
        logic [14:0] exp;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            for (int i = 0; i < 3; i++) begin
                exp = (i == 0) ? F0 : (i == 1) ? F1 : ex2[k];
                #1;
                n_cmp++;
                if (strobes() !== exp || bus.step !== 3'(i)) begin
                    n_bad++;
                    $display("FAIL b2b op=%h T%0d got=%h step=%0d want=%h", ops[k], i, strobes(),
                             bus.step, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_invariant_sweep();
        int cyc;
        int want;
        for (int op = 0; op < 16; op++) begin
            for (int fz = 0; fz < 4; fz++) begin
                bus.opcode = 4'(op);
                bus.cf = fz[0];
                bus.zf = fz[1];
                do_reset();
                want = (op == 1 || op == 4) ? 4 : (op == 2 || op == 3) ? 5 : 3;
                cyc = 0;
                do begin
                    #1;
                    n_cmp++;
                    if ($countones({bus.pc_rd, bus.ram_rd, bus.ir_rd, bus.a_rd, bus.alu_rd}) > 1) begin
                        n_bad++;
                        $display("FAIL bus_drivers op=%h cf=%b zf=%b step=%0d got=%h", bus.opcode,
                                 bus.cf, bus.zf, bus.step, strobes());
                    end
                    if (op >= 9 && op <= 13 && bus.step >= 3'd2) begin
                        n_cmp++;
                        if (strobes() !== NONE) begin
                            n_bad++;
                            $display("FAIL undef_exec op=%h got=%h want=%h", bus.opcode, strobes(),
                                     NONE);
                        end
                    end
                    tick();
                    cyc++;
                end while (bus.step !== 3'd0 && cyc < 8);
                n_cmp++;
                if (cyc != want) begin
                    n_bad++;
                    $display("FAIL instr_len op=%h cf=%b zf=%b got=%0d want=%0d", bus.opcode,
                             bus.cf, bus.zf, cyc, want);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_sub();
        test_cond_jump();
        test_halt();
        test_run_gating();
        test_mid_reset();
        test_back_to_back();
        test_invariant_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Micro-step sequencer and instruction decoder for the 8-bit bus CPU.
- It is the initiator side of the register/bus control interface. It generates every wr_en/rd_en strobe for PC, MAR, RAM, IR, A, B, ALU and OUT, once per clock.
- Sits between the IR opcode nibble, the ALU flags and the datapath.
- Enforces a single bus driver per cycle.

Parameters:
- OPW, 4, opcode width (upper IR nibble).
- STEPS, 5, micro-steps T0..T4; step counter is 3 bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- run  in  1  advance enable; 0 freezes the step and forces all strobes to 0.
- opcode  in  OPW  IR[7:4]; sampled from T2 onward.
- cf  in  1  ALU carry flag (registered externally).
- zf  in  1  ALU zero flag (registered externally).
- pc_inc  out  1  program counter increment.
- pc_rd  out  1  PC drives bus.
- pc_wr  out  1  PC loads from bus.
- mar_wr  out  1  MAR loads from bus.
- ram_rd  out  1  RAM drives bus.
- ram_wr  out  1  RAM writes from bus.
- ir_wr  out  1  IR loads from bus.
- ir_rd  out  1  IR low nibble drives bus, zero-extended.
- a_wr  out  1  A register loads.
- a_rd  out  1  A register drives bus.
- b_wr  out  1  B register loads.
- alu_rd  out  1  ALU result drives bus.
- alu_sub  out  1  ALU subtract select.
- flag_wr  out  1  flag register loads.
- out_wr  out  1  output register loads.
- halted  out  1  CPU halted.
- step  out  3  current micro-step, for debug.

Behaviour:
- State: step[2:0] (T0..T4) and the halted flag, both registered.
- Strobes are combinational decode of (step, opcode, cf, zf), ANDed with run & ~halted & ~clr.
- clr=1 at a posedge: step<=0, halted<=0. While clr is high, all strobes are 0. This applies mid-instruction too; the in-flight instruction is abandoned with no partial write.
- Advance rule, at posedge with run=1, ~halted, ~clr:
  - if the current step is the last step of the instruction, step<=0;
  - otherwise step<=step+1.
- run=0: step holds and no strobe is asserted.
- Fetch, common to all instructions:
  - T0: pc_rd, mar_wr.
  - T1: ram_rd, ir_wr, pc_inc.
- Execute, from T2; last step marked (L):
  - 0000 NOP: T2 none (L).
  - 0001 LDA: T2 ir_rd, mar_wr; T3 ram_rd, a_wr (L).
  - 0010 ADD: T2 ir_rd, mar_wr; T3 ram_rd, b_wr; T4 alu_rd, a_wr, flag_wr (L).
  - 0011 SUB: as ADD, with alu_sub=1 in T4 only.
  - 0100 STA: T2 ir_rd, mar_wr; T3 a_rd, ram_wr (L).
  - 0101 LDI: T2 ir_rd, a_wr (L).
  - 0110 JMP: T2 ir_rd, pc_wr (L).
  - 0111 JC: T2 ir_rd, pc_wr only if cf=1, otherwise none (L).
  - 1000 JZ: as JC using zf.
  - 1110 OUT: T2 a_rd, out_wr (L).
  - 1111 HLT: T2 no strobes. At the end of T2, halted<=1 and step<=0. halted stays set until clr; all strobes are 0 while halted.
  - 1001..1101: undefined; execute as NOP.
- Bus-driver invariant: at most one of pc_rd, ram_rd, ir_rd, a_rd, alu_rd is high in any cycle.
- Cycle count per instruction (T0 to the next T0):
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT, HLT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- step never exceeds 4. A corrupt value 5..7 decodes to no strobes and returns to 0 on the next advance.
- Flags are sampled combinationally in T2 of JC/JZ; a flag change in that same cycle is honoured.

Test Plan:
- Reset and fetch: clr=1 for 2 cycles, then run=1 → step=0 with pc_rd=1 and mar_wr=1; next cycle ram_rd=1, ir_wr=1, pc_inc=1; during clr every strobe is 0.
- ADD sequence: opcode=0010 → T2 ir_rd+mar_wr, T3 ram_rd+b_wr, T4 alu_rd+a_wr+flag_wr with alu_sub=0, then step=0. SUB (0011) gives the same sequence with alu_sub=1 in T4 only.
- Conditional jump: JC with cf=0 → no strobes in T2, step back to 0 after 3 cycles. JC with cf=1 → ir_rd+pc_wr in T2. JZ with zf=1 → ir_rd+pc_wr in T2.
- Halt: opcode=1111 → halted=1 after T2; run held at 1 for 10 cycles gives all strobes 0 and step=0. Then clr pulse → halted=0 and fetch resumes.
- run gating and mid-op reset: run=0 during T3 of LDA → step holds at 3, ram_rd=a_wr=0; run=1 resumes T3. clr asserted at T3 of STA → no ram_wr, step=0 next cycle.
- Invariant sweep: all 16 opcodes × cf/zf combinations → at most one bus driver per cycle; undefined opcodes 1001..1101 take 3 cycles with no execute strobes.
